// File: rtl/jt12_eg_mux_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jt12_eg_mux_if                                                     |
// | Bus between the slot sequencer / register file and the             |
// | time-multiplexed envelope generator.                               |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface jt12_eg_mux_if #(
   parameter int SLOTS = 24,
   parameter int EGW   = 10
);
   localparam int SW = $clog2(SLOTS);

   logic          clk_en;
   logic          eg_stop;
   logic          keyon;
   logic [4:0]    arate;
   logic [4:0]    rate1;
   logic [4:0]    rate2;
   logic [3:0]    rrate;
   logic [3:0]    d1l;
   logic [1:0]    ks;
   logic [4:0]    keycode;
   logic [6:0]    tl;
   logic [SW-1:0] slot;
   logic          zero;
   logic [EGW-1:0] eg_out;
   logic [SW-1:0] eg_slot;

   modport master (
      output clk_en, eg_stop, keyon, arate, rate1, rate2, rrate, d1l, ks, keycode, tl,
      input  slot, zero, eg_out, eg_slot
   );

   modport slave (
      input  clk_en, eg_stop, keyon, arate, rate1, rate2, rrate, d1l, ks, keycode, tl,
      output slot, zero, eg_out, eg_slot
   );
endinterface
`default_nettype wire

// File: rtl/jt12_eg_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jt12_eg_mux                                                        |
// | Time-multiplexed ADSR envelope generator. One slot is serviced per |
// | clk_en; per-slot state, attenuation and last key live in arrays.   |
// | Optional feature macro: JT12_EG_DAMP_EN (damp before attack).      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module jt12_eg_mux #(
   parameter int SLOTS = 24,
   parameter int EGW   = 10,
   parameter int CNTW  = 15
) (
   input wire logic        clk,
   input wire logic        rst,
   jt12_eg_mux_if.slave    bus
);
   localparam int SW = $clog2(SLOTS);
   localparam logic [SW-1:0]  c_LAST = SW'(SLOTS - 1);
   localparam logic [EGW-1:0] c_MAX  = {EGW{1'b1}};

   localparam logic [2:0] c_ST_ATTACK  = 3'd0;
   localparam logic [2:0] c_ST_DECAY1  = 3'd1;
   localparam logic [2:0] c_ST_DECAY2  = 3'd2;
   localparam logic [2:0] c_ST_DAMP    = 3'd4;
   localparam logic [2:0] c_ST_RELEASE = 3'd7;

   logic [SW-1:0]   slot_q, slot_d;
   logic [1:0]      div_q, div_d;
   logic [CNTW-1:0] eg_cnt_q, eg_cnt_d;
   logic [EGW-1:0]  eg_out_q, eg_out_d;
   logic [SW-1:0]   eg_slot_q;

   logic [2:0]      state_q [SLOTS];
   logic [EGW-1:0]  eg_q    [SLOTS];
   logic            kon_q   [SLOTS];

   logic [2:0]      cur_state, state_d, state_upd;
   logic [EGW-1:0]  cur_eg, eg_d;
   logic            cur_kon, kon_rise, kon_fall;
   logic [4:0]      sl;

   logic [4:0]      cfg;
   logic [6:0]      rsum;
   logic [5:0]      rate;
   logic [3:0]      rhi, shift;
   logic [CNTW-1:0] mask;
   logic            tick;
   logic [2:0]      idx;
   logic [7:0]      pattern;
   logic [3:0]      inc;
   logic [EGW+4:0]  mul_a, prod;
   logic [EGW:0]    dsum, out_sum;
   logic [EGW-1:0]  eg_new;

   assign cur_state = state_q[slot_q];
   assign cur_eg    = eg_q[slot_q];
   assign cur_kon   = kon_q[slot_q];
   assign kon_rise  = bus.keyon & ~cur_kon;
   assign kon_fall  = ~bus.keyon & cur_kon;
   assign sl        = (bus.d1l == 4'hF) ? 5'd31 : {1'b0, bus.d1l};

   // State register: slot sequencer, round divider, envelope counter and per-slot RMW
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q    <= '0;
         div_q     <= '0;
         eg_cnt_q  <= '0;
         eg_out_q  <= c_MAX;
         eg_slot_q <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            state_q[i] <= c_ST_RELEASE;
            eg_q[i]    <= c_MAX;
            kon_q[i]   <= 1'b0;
         end
      end else if (bus.clk_en) begin
         slot_q    <= slot_d;
         div_q     <= div_d;
         eg_cnt_q  <= eg_cnt_d;
         eg_out_q  <= eg_out_d;
         eg_slot_q <= slot_q;
         if (!bus.eg_stop) begin
            state_q[slot_q] <= state_upd;
            eg_q[slot_q]    <= eg_d;
            kon_q[slot_q]   <= bus.keyon;
         end
      end
   end

   // Next-state: key edges first, then level-driven phase changes
   always_comb begin
      state_d = cur_state;
      if (kon_rise) begin
`ifdef JT12_EG_DAMP_EN
         state_d = (cur_eg != c_MAX) ? c_ST_DAMP : c_ST_ATTACK;
`else
         state_d = c_ST_ATTACK;
`endif
      end else if (kon_fall) begin
         state_d = c_ST_RELEASE;
      end else begin
         case (cur_state)
            c_ST_ATTACK: if (cur_eg == '0) state_d = c_ST_DECAY1;
            c_ST_DECAY1: if (cur_eg[EGW-1 -: 5] >= sl) state_d = c_ST_DECAY2;
            default:     state_d = cur_state;
         endcase
      end
   end

   // Output/datapath: rate, tick, increment, attenuation update and final level
   always_comb begin
      case (state_d)
         c_ST_ATTACK:  cfg = bus.arate;
         c_ST_DECAY1:  cfg = bus.rate1;
         c_ST_DECAY2:  cfg = bus.rate2;
         c_ST_RELEASE: cfg = {bus.rrate, 1'b1};
         default:      cfg = 5'd0;
      endcase

      rsum = {1'b0, cfg, 1'b0} + 7'(bus.keycode >> (2'd3 - bus.ks));
      if (cfg == 5'd0)        rate = 6'd0;
      else if (rsum > 7'd63)  rate = 6'd63;
      else                    rate = rsum[5:0];

      rhi   = rate[5:2];
      shift = (rhi < 4'd11) ? (4'd11 - rhi) : 4'd0;
      mask  = ~({CNTW{1'b1}} << shift);
      tick  = ((eg_cnt_q & mask) == '0);
      idx   = 3'(eg_cnt_q >> shift);

      case (rate[1:0])
         2'd0:    pattern = 8'b10101010;
         2'd1:    pattern = 8'b11101010;
         2'd2:    pattern = 8'b11101110;
         default: pattern = 8'b11111110;
      endcase

      if (rate < 6'd2 || !tick)  inc = 4'd0;
      else if (rhi < 4'd12)      inc = {3'b000, pattern[idx]};
      else if (rhi == 4'd15)     inc = 4'd8;
      else                       inc = ({3'b000, pattern[idx]} + 4'd1) << rhi[1:0];

      mul_a     = (EGW+5)'(cur_eg >> 4) + (EGW+5)'(1);
      prod      = mul_a * (EGW+5)'(inc);
      dsum      = {1'b0, cur_eg} + ((state_d == c_ST_DAMP) ? (EGW+1)'(8) : (EGW+1)'(inc));
      eg_d      = cur_eg;
      state_upd = state_d;

      case (state_d)
         c_ST_ATTACK: begin
            if (kon_rise && rate >= 6'd62)             eg_d = '0;
            else if (prod >= (EGW+5)'(cur_eg))         eg_d = '0;
            else                                       eg_d = cur_eg - prod[EGW-1:0];
         end
         c_ST_DAMP: begin
            eg_d = dsum[EGW] ? c_MAX : dsum[EGW-1:0];
            if (eg_d == c_MAX) state_upd = c_ST_ATTACK;
         end
         default: eg_d = dsum[EGW] ? c_MAX : dsum[EGW-1:0];
      endcase

      eg_new   = bus.eg_stop ? cur_eg : eg_d;
      out_sum  = {1'b0, eg_new} + {1'b0, bus.tl, {(EGW-7){1'b0}}};
      eg_out_d = out_sum[EGW] ? c_MAX : out_sum[EGW-1:0];

      slot_d   = (slot_q == c_LAST) ? '0 : slot_q + SW'(1);
      div_d    = div_q;
      eg_cnt_d = eg_cnt_q;
      if (slot_q == c_LAST) begin
         if (div_q == 2'd2) begin
            div_d    = 2'd0;
            eg_cnt_d = eg_cnt_q + CNTW'(1);
         end else begin
            div_d    = div_q + 2'd1;
         end
      end
   end

   assign bus.slot    = slot_q;
   assign bus.zero    = (slot_q == c_LAST);
   assign bus.eg_out  = eg_out_q;
   assign bus.eg_slot = eg_slot_q;

endmodule
`default_nettype wire

// File: tb/tb_jt12_eg_mux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jt12_eg_mux                                                     |
// | Directed bench for jt12_eg_mux with hand-computed expectations.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_jt12_eg_mux;
   localparam int SLOTS = 24;
   localparam int EGW   = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic       kon [SLOTS];
   logic [4:0] ar  [SLOTS];
   logic [4:0] r1  [SLOTS];
   logic [4:0] r2  [SLOTS];
   logic [3:0] rr  [SLOTS];
   logic [3:0] sl  [SLOTS];
   logic [1:0] ks  [SLOTS];
   logic [4:0] kc  [SLOTS];
   logic [6:0] tl  [SLOTS];

   always #5 clk = ~clk;

   jt12_eg_mux_if #(.SLOTS(SLOTS), .EGW(EGW)) bus ();

   jt12_eg_mux #(.SLOTS(SLOTS), .EGW(EGW), .CNTW(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic drive();
      int s;
      s = int'(bus.slot);
      bus.keyon   = kon[s];
      bus.arate   = ar[s];
      bus.rate1   = r1[s];
      bus.rate2   = r2[s];
      bus.rrate   = rr[s];
      bus.d1l     = sl[s];
      bus.ks      = ks[s];
      bus.keycode = kc[s];
      bus.tl      = tl[s];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // step until the output belongs to slot n (bounded)
   task automatic wait_out(input int n);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (int'(bus.eg_slot) != n && k < 2*SLOTS);
      check("eg_slot", 32'(bus.eg_slot), 32'(n));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] expv;
      for (int i = 0; i < SLOTS; i++) begin
         kon[i] = 1'b0; ar[i] = '0; r1[i] = '0; r2[i] = '0; rr[i] = '0;
         sl[i]  = '0;   ks[i] = '0; kc[i] = '0; tl[i] = '0;
      end
      bus.clk_en  = 1'b1;
      bus.eg_stop = 1'b0;
      drive();

      // reset state
      #12;
      check("rst_eg_out", 32'(bus.eg_out), 32'h3FF);
      check("rst_eg_slot", 32'(bus.eg_slot), 32'd0);
      check("rst_slot", 32'(bus.slot), 32'd0);
      check("rst_zero", 32'(bus.zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive();

      // slot counter and zero flag
      for (int i = 0; i < SLOTS-2; i++) step();
      check("zero_early", 32'(bus.zero), 32'd0);
      step();
      check("slot_last", 32'(bus.slot), 32'd23);
      check("zero_last", 32'(bus.zero), 32'd1);
      step();
      check("slot_wrap", 32'(bus.slot), 32'd0);
      check("zero_wrap", 32'(bus.zero), 32'd0);

      // slot 3: instant attack, then DECAY1, then total-level cases
      kon[3] = 1'b1; ar[3] = 5'd31; r1[3] = 5'd31; sl[3] = 4'd15; tl[3] = 7'd1;
      drive();
      wait_out(3);
      check("atk_tl1", 32'(bus.eg_out), 32'h008);
      tl[3] = 7'd0; drive();
      wait_out(3);
      check("decay1_first", 32'(bus.eg_out), 32'h008);
      tl[3] = 7'd127; drive();
      wait_out(3);
      check("tl_sat", 32'(bus.eg_out), 32'h3FF);
      tl[3] = 7'd0; r1[3] = 5'd0; drive();
      wait_out(3);
      check("decay1_hold", 32'(bus.eg_out), 32'h010);

      // slot 0: key-scaled max decay rate, sustain level 2
      kon[0] = 1'b1; ar[0] = 5'd31; r1[0] = 5'd31; r2[0] = 5'd0; sl[0] = 4'd2;
      kc[0] = 5'd31; ks[0] = 2'd3; drive();
      wait_out(0);
      check("s0_atk", 32'(bus.eg_out), 32'h000);
      for (int v = 2; v <= 11; v++) begin
         wait_out(0);
         check("s0_decay", 32'(bus.eg_out), (8*(v-1) > 32'h40) ? 32'h40 : 32'(8*(v-1)));
      end

      // slot 0: keyoff with slow release, then retrigger
      kon[0] = 1'b0; r1[0] = 5'd0; kc[0] = 5'd0; ks[0] = 2'd0; drive();
      wait_out(0);
      check("s0_rel_slow", 32'(bus.eg_out), 32'h040);
      kon[0] = 1'b1; drive();
      wait_out(0);
`ifdef JT12_EG_DAMP_EN
      check("s0_retrig_damp", 32'(bus.eg_out), 32'h048);
`else
      check("s0_retrig_atk", 32'(bus.eg_out), 32'h000);
`endif

      // slot 3: fast release from 0x010 with one frozen round
      kon[3] = 1'b0; rr[3] = 4'd15; drive();
      expv = 10'h010;
      for (int k = 1; k <= 130; k++) begin
         if (k == 60) bus.eg_stop = 1'b1;
         wait_out(3);
         if (k != 60) expv = (expv > 10'h3F7) ? 10'h3FF : expv + 10'd8;
         check("s3_release", 32'(bus.eg_out), 32'(expv));
         bus.eg_stop = 1'b0;
      end

      // asynchronous reset mid-round
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_eg_out", 32'(bus.eg_out), 32'h3FF);
      check("mid_rst_eg_slot", 32'(bus.eg_slot), 32'd0);
      check("mid_rst_slot", 32'(bus.slot), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive();
      for (int i = 0; i < SLOTS-2; i++) step();
      check("post_rst_zero_early", 32'(bus.zero), 32'd0);
      step();
      check("post_rst_zero", 32'(bus.zero), 32'd1);
      wait_out(3);
      check("post_rst_s3", 32'(bus.eg_out), 32'h3FF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
